// File: rtl/ysyx_axi4_mem_slave_pkg.sv
// Shared AXI4 encodings and FSM state types for the NPC simulation memory responder.
package ysyx_axi4_mem_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_BEAT
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  // Only INCR bursts of at most 8 bytes per beat are served.
  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_INCR) && (size <= 3'd3);
  endfunction

endpackage

// File: rtl/ysyx_axi4_burst_addr.sv
// Beat address helper: next INCR address, array hit test and word index for one beat.
module ysyx_axi4_burst_addr
  import ysyx_axi4_mem_slave_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
  parameter int                MEM_DEPTH = 4096,
  localparam int               IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              in_range_o,
  output logic              legal_o,
  output logic [IDX_W-1:0]  word_idx_o
);

  logic [ADDR_W-1:0] offset;

  // Unsigned offset compare covers both ends of the window, including wrap below MEM_BASE.
  always_comb begin
    next_addr_o = addr_i + (ADDR_W'(1) << size_i);
    offset      = addr_i - MEM_BASE;
    in_range_o  = (offset < ADDR_W'(MEM_DEPTH * 8));
    word_idx_o  = offset[IDX_W+2:3];
    legal_o     = burst_legal(burst_i, size_i);
  end

endmodule

// File: rtl/ysyx_axi4_mem_slave.sv
// AXI4 memory responder with independent read/write burst FSMs over a byte-strobed array.
// Optional macro YSYX_AXI_RAND_DELAY_EN adds LFSR-driven ready/valid back-pressure.
module ysyx_axi4_mem_slave
  import ysyx_axi4_mem_slave_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
  parameter int                MEM_DEPTH = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  rstate_e           rstate_q, rstate_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;

  wstate_e           wstate_q, wstate_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [8:0]        wbeat_q, wbeat_d;
  logic              werr_q, werr_d, wdec_q, wdec_d;

  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic              rd_load, mem_we, overflow, err_now, dec_now;
  logic [ADDR_W-1:0] rd_addr, rd_next, wr_next;
  logic [2:0]        rd_size;
  logic [1:0]        rd_burst;
  logic              rd_in_range, rd_legal, wr_in_range, wr_legal;
  logic [IDX_W-1:0]  rd_idx, wr_idx;

`ifdef YSYX_AXI_RAND_DELAY_EN
  logic [19:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[18]};
`endif

  assign ar_hs = arvalid & arready_q;
  assign r_hs  = rvalid_q & rready;
  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;
  assign b_hs  = bvalid_q & bready;

  // raddr_q holds the address of the next beat to fetch, so the idle mux feeds araddr directly.
  assign rd_addr  = (rstate_q == R_IDLE) ? araddr  : raddr_q;
  assign rd_size  = (rstate_q == R_IDLE) ? arsize  : rsize_q;
  assign rd_burst = (rstate_q == R_IDLE) ? arburst : rburst_q;

  ysyx_axi4_burst_addr #(
    .ADDR_W(ADDR_W), .MEM_BASE(MEM_BASE), .MEM_DEPTH(MEM_DEPTH)
  ) u_rd_addr (
    .addr_i(rd_addr), .size_i(rd_size), .burst_i(rd_burst),
    .next_addr_o(rd_next), .in_range_o(rd_in_range), .legal_o(rd_legal), .word_idx_o(rd_idx)
  );

  ysyx_axi4_burst_addr #(
    .ADDR_W(ADDR_W), .MEM_BASE(MEM_BASE), .MEM_DEPTH(MEM_DEPTH)
  ) u_wr_addr (
    .addr_i(waddr_q), .size_i(wsize_q), .burst_i(wburst_q),
    .next_addr_o(wr_next), .in_range_o(wr_in_range), .legal_o(wr_legal), .word_idx_o(wr_idx)
  );

  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    raddr_d  = raddr_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rlen_d   = rlen_q;
    rbeat_d  = rbeat_q;
    rd_load  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d    = arid;
          rsize_d  = arsize;
          rburst_d = arburst;
          rlen_d   = arlen;
          rbeat_d  = 8'd0;
          rlast_d  = (arlen == 8'd0);
          rd_load  = 1'b1;
          rstate_d = R_BEAT;
`ifdef YSYX_AXI_RAND_DELAY_EN
          rvalid_d = 1'b0;
`else
          rvalid_d = 1'b1;
`endif
        end
      end
      R_BEAT: begin
`ifdef YSYX_AXI_RAND_DELAY_EN
        if (!rvalid_q && lfsr_q[19]) rvalid_d = 1'b1;
`endif
        if (r_hs) begin
          if (rbeat_q == rlen_q) begin
            rstate_d = R_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            rbeat_d = rbeat_q + 8'd1;
            rlast_d = ((rbeat_q + 8'd1) == rlen_q);
            rd_load = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    // Beat data is sampled from the array before any same-edge write commits.
    if (rd_load) begin
      raddr_d = rd_next;
      if (!rd_in_range) begin
        rresp_d = RESP_DECERR;
        rdata_d = '0;
      end else if (!rd_legal) begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = mem[rd_idx];
      end
    end
`ifdef YSYX_AXI_RAND_DELAY_EN
    arready_d = (rstate_d == R_IDLE) && lfsr_d[0];
`else
    arready_d = (rstate_d == R_IDLE);
`endif
  end

  always_comb begin
    wstate_d = wstate_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    waddr_d  = waddr_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wlen_d   = wlen_q;
    wbeat_d  = wbeat_q;
    werr_d   = werr_q;
    wdec_d   = wdec_q;
    mem_we   = 1'b0;
    overflow = 1'b0;
    err_now  = werr_q;
    dec_now  = wdec_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          bid_d    = awid;
          waddr_d  = awaddr;
          wsize_d  = awsize;
          wburst_d = awburst;
          wlen_d   = awlen;
          wbeat_d  = 9'd0;
          werr_d   = 1'b0;
          wdec_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          // Beats past awlen are swallowed; the counter saturates so it never aliases back.
          overflow = (wbeat_q > {1'b0, wlen_q});
          err_now  = werr_q | overflow | !wr_legal | (wlast && (wbeat_q != {1'b0, wlen_q}));
          dec_now  = wdec_q | (!overflow && !wr_in_range);
          mem_we   = !overflow && wr_in_range && wr_legal;
          waddr_d  = wr_next;
          wbeat_d  = wbeat_q[8] ? wbeat_q : wbeat_q + 9'd1;
          werr_d   = err_now;
          wdec_d   = dec_now;
          if (wlast) begin
            wstate_d = W_RESP;
            bresp_d  = dec_now ? RESP_DECERR : (err_now ? RESP_SLVERR : RESP_OKAY);
`ifdef YSYX_AXI_RAND_DELAY_EN
            bvalid_d = 1'b0;
`else
            bvalid_d = 1'b1;
`endif
          end
        end
      end
      W_RESP: begin
`ifdef YSYX_AXI_RAND_DELAY_EN
        if (!bvalid_q && lfsr_q[19]) bvalid_d = 1'b1;
`endif
        if (b_hs) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
`ifdef YSYX_AXI_RAND_DELAY_EN
    awready_d = (wstate_d == W_IDLE) && lfsr_d[1];
    wready_d  = (wstate_d == W_DATA) && lfsr_d[2];
`else
    awready_d = (wstate_d == W_IDLE);
    wready_d  = (wstate_d == W_DATA);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
`ifdef YSYX_AXI_RAND_DELAY_EN
      lfsr_q    <= 20'd1;
`endif
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
`ifdef YSYX_AXI_RAND_DELAY_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    raddr_q  <= raddr_d;
    rsize_q  <= rsize_d;
    rburst_q <= rburst_d;
    rlen_q   <= rlen_d;
    rbeat_q  <= rbeat_d;
    waddr_q  <= waddr_d;
    wsize_q  <= wsize_d;
    wburst_q <= wburst_d;
    wlen_q   <= wlen_d;
    wbeat_q  <= wbeat_d;
    werr_q   <= werr_d;
    wdec_q   <= wdec_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_ysyx_axi4_mem_slave.sv
// Directed bench for ysyx_axi4_mem_slave: vector table of single-beat transfers plus burst/reset sequences.
module tb_ysyx_axi4_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;

  int tests = 0;
  int fails = 0;

  logic [63:0] rd_data [8];
  logic [1:0]  rd_resp [8];
  logic        rd_last [8];

  always #5 clk = ~clk;

  ysyx_axi4_mem_slave dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input logic [63:0] data0,
                           input logic [7:0] strb, input logic [3:0] id, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; awsize = size; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("aw_wait");
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      wdata = data0 + 64'(k); wstrb = strb; wlast = (k == nbeats - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("w_wait");
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("b_wait");
    resp = bresp;
    chk("bid_echo", 64'(bid), 64'(id));
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id);
    int n;
    @(negedge clk);
    araddr = addr; arsize = size; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("ar_wait");
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("r_wait");
      rd_data[k] = rdata; rd_resp[k] = rresp; rd_last[k] = rlast;
      chk("rid_echo", 64'(rid), 64'(id));
      @(negedge clk);
    end
    rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [63:0] held;
    logic        stalled;
    int          beat, n;

    vecs[0]  = '{1'b1, 32'h8000_0000, 3'd3, 2'b01, 64'h1122334455667788, 8'hFF, 64'h0, 2'b00};
    vecs[1]  = '{1'b1, 32'h8000_0004, 3'd2, 2'b01, 64'hDEADBEEF00000000, 8'hF0, 64'h0, 2'b00};
    vecs[2]  = '{1'b0, 32'h8000_0000, 3'd3, 2'b01, 64'h0, 8'h00, 64'hDEADBEEF55667788, 2'b00};
    vecs[3]  = '{1'b1, 32'h8000_1000, 3'd3, 2'b01, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 2'b00};
    vecs[4]  = '{1'b1, 32'h0000_1000, 3'd3, 2'b01, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 2'b11};
    vecs[5]  = '{1'b0, 32'h8000_1000, 3'd3, 2'b01, 64'h0, 8'h00, 64'h0123456789ABCDEF, 2'b00};
    vecs[6]  = '{1'b0, 32'h0000_1000, 3'd3, 2'b01, 64'h0, 8'h00, 64'h0, 2'b11};
    vecs[7]  = '{1'b1, 32'h8000_7FF8, 3'd3, 2'b01, 64'hCAFEF00D12345678, 8'hFF, 64'h0, 2'b00};
    vecs[8]  = '{1'b0, 32'h8000_7FF8, 3'd3, 2'b01, 64'h0, 8'h00, 64'hCAFEF00D12345678, 2'b00};
    vecs[9]  = '{1'b1, 32'h8000_8000, 3'd3, 2'b01, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 64'h0, 2'b11};
    vecs[10] = '{1'b0, 32'h8000_8000, 3'd3, 2'b01, 64'h0, 8'h00, 64'h0, 2'b11};
    vecs[11] = '{1'b1, 32'h8000_0008, 3'd3, 2'b01, 64'h0, 8'hFF, 64'h0, 2'b00};
    vecs[12] = '{1'b1, 32'h8000_0008, 3'd3, 2'b01, 64'hFFFFFFFFFFFFFFFF, 8'h81, 64'h0, 2'b00};
    vecs[13] = '{1'b0, 32'h8000_0008, 3'd3, 2'b01, 64'h0, 8'h00, 64'hFF000000000000FF, 2'b00};
    vecs[14] = '{1'b1, 32'h8000_0000, 3'd3, 2'b00, 64'h0, 8'hFF, 64'h0, 2'b10};
    vecs[15] = '{1'b0, 32'h8000_0000, 3'd3, 2'b01, 64'h0, 8'h00, 64'hDEADBEEF55667788, 2'b00};
    vecs[16] = '{1'b0, 32'h8000_0000, 3'd3, 2'b10, 64'h0, 8'h00, 64'h0, 2'b10};
    vecs[17] = '{1'b0, 32'h8000_0000, 3'd4, 2'b01, 64'h0, 8'h00, 64'h0, 2'b10};
    vecs[18] = '{1'b1, 32'h0000_1000, 3'd3, 2'b00, 64'h0, 8'hFF, 64'h0, 2'b11};
    vecs[19] = '{1'b0, 32'hFFFF_FFF8, 3'd3, 2'b01, 64'h0, 8'h00, 64'h0, 2'b11};

    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_resp", {60'd0, rresp, bresp}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", 64'(arready), 64'd1);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_wready", 64'(wready), 64'd0);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].size, 8'd0, vecs[i].burst, 1, vecs[i].data, vecs[i].strb,
                  4'(i), resp);
        chk($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, vecs[i].size, 8'd0, vecs[i].burst, 4'(i));
        chk($sformatf("vec%0d_rdata", i), rd_data[0], vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 64'(rd_resp[0]), 64'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rlast", i), 64'(rd_last[0]), 64'd1);
      end
    end

    // INCR write burst to words 2..5, then read back with rready toggling
    axi_write(32'h8000_0010, 3'd3, 8'd3, 2'b01, 4, 64'h1000, 8'hFF, 4'h3, resp);
    chk("wburst_bresp", 64'(resp), 64'd0);
    @(negedge clk);
    araddr = 32'h8000_0010; arsize = 3'd3; arlen = 8'd3; arburst = 2'b01; arid = 4'h5; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("burst_ar_wait");
    @(negedge clk);
    arvalid = 1'b0;
    beat = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 40 && beat < 4; c++) begin
      rready = c[0];
      if (stalled) chk("stall_stable", rdata, held);
      if (rvalid) begin
        if (rready) begin
          chk($sformatf("burst_beat%0d", beat), rdata, 64'h1000 + 64'(beat));
          chk($sformatf("burst_rlast%0d", beat), 64'(rlast), 64'(beat == 3));
          beat++;
          stalled = 1'b0;
        end else begin
          held = rdata;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
    end
    rready = 1'b0;
    chk("burst_beats", 64'(beat), 64'd4);
    chk("burst_arready_back", 64'(arready), 64'd1);
    chk("burst_rvalid_off", 64'(rvalid), 64'd0);

    // Overlong write: second beat past awlen is consumed but not written
    axi_write(32'h8000_0048, 3'd3, 8'd0, 2'b01, 1, 64'h5555, 8'hFF, 4'h1, resp);
    chk("pre_ovf_bresp", 64'(resp), 64'd0);
    axi_write(32'h8000_0040, 3'd3, 8'd0, 2'b01, 2, 64'hA0, 8'hFF, 4'h2, resp);
    chk("ovf_bresp", 64'(resp), 64'd2);
    axi_read(32'h8000_0040, 3'd3, 8'd1, 2'b01, 4'h4);
    chk("ovf_beat0_written", rd_data[0], 64'hA0);
    chk("ovf_beat1_dropped", rd_data[1], 64'h5555);

    // Early wlast on a two-beat write
    axi_write(32'h8000_0050, 3'd3, 8'd1, 2'b01, 1, 64'hB0, 8'hFF, 4'h6, resp);
    chk("early_wlast_bresp", 64'(resp), 64'd2);

    // WRAP read burst: every beat reports SLVERR with zero data
    axi_read(32'h8000_0000, 3'd3, 8'd1, 2'b10, 4'h7);
    chk("wrap_resp0", 64'(rd_resp[0]), 64'd2);
    chk("wrap_resp1", 64'(rd_resp[1]), 64'd2);
    chk("wrap_data0", rd_data[0], 64'd0);
    chk("wrap_last", {62'd0, rd_last[0], rd_last[1]}, 64'd1);

    // Concurrent W beat and AR to the same word in one cycle
    axi_write(32'h8000_0100, 3'd3, 8'd0, 2'b01, 1, 64'h1111, 8'hFF, 4'h8, resp);
    @(negedge clk);
    awaddr = 32'h8000_0100; awsize = 3'd3; awlen = 8'd0; awburst = 2'b01; awid = 4'h9; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("conc_aw_wait");
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 64'h2222; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 32'h8000_0100; arsize = 3'd3; arlen = 8'd0; arburst = 2'b01; arid = 4'hA; arvalid = 1'b1;
    chk("conc_both_ready", {62'd0, arready, wready}, 64'd3);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("conc_old_data", rdata, 64'h1111);
    chk("conc_bvalid", 64'(bvalid), 64'd1);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h8000_0100, 3'd3, 8'd0, 2'b01, 4'hB);
    chk("conc_new_data", rd_data[0], 64'h2222);

    // Reset during beat 2 of an 8-beat read
    @(negedge clk);
    araddr = 32'h8000_0010; arsize = 3'd3; arlen = 8'd7; arburst = 2'b01; arid = 4'hC; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("rstb_ar_wait");
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstb_beat2", rdata, 64'h1002);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rready = 1'b0;
    chk("rstb_rvalid", 64'(rvalid), 64'd0);
    chk("rstb_arready_low", 64'(arready), 64'd0);
    @(negedge clk);
    chk("rstb_arready_back", 64'(arready), 64'd1);
    axi_read(32'h8000_0018, 3'd3, 8'd0, 2'b01, 4'hD);
    chk("rstb_fresh_data", rd_data[0], 64'h1001);
    chk("rstb_fresh_resp", {61'd0, rd_resp[0], rd_last[0]}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_axi4_mem_slave.md
Name: ysyx_axi4_mem_slave

Overview:
AXI4 responder (slave) that receives the core's 64-bit io_master_* AXI4 traffic and serves it from an internal byte-strobed memory array. Used in NPC simulation as the memory endpoint for IFU/LSU requests. Read and write channels run independent FSMs, support INCR bursts, and report SLVERR/DECERR per AXI4.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data bus width (fixed 64; strobe width DATA_W/8)
ID_W, 4, transaction ID width
MEM_BASE, 32'h8000_0000, base byte address of the array
MEM_DEPTH, 4096, array depth in 64-bit words (power of two)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arid  in  ID_W  read ID
araddr  in  ADDR_W  read start byte address
arlen  in  8  beats minus 1
arsize  in  3  log2 bytes per beat (0..3)
arburst  in  2  burst type
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_W  echoed arid
rdata  out  DATA_W  read data, bus-aligned (lane = addr[2])
rresp  out  2  OKAY=00, SLVERR=10, DECERR=11
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  ID_W  write ID
awaddr  in  ADDR_W  write start byte address
awlen  in  8  beats minus 1
awsize  in  3  log2 bytes per beat
awburst  in  2  burst type
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_W  write data, bus-aligned
wstrb  in  DATA_W/8  byte strobes
wlast  in  1  final write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_W  echoed awid
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (rst high at a clk edge): both FSMs return to idle from any state, including mid-burst; arready, awready, rvalid, rlast, wready, bvalid = 0; rid, rdata, rresp, bid, bresp = 0. Array contents are not reset. arready/awready go to 1 on the first cycle after rst deasserts.
- Read FSM R_IDLE -> R_BEAT -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready, latch id, addr, len, size, burst; clear beat counter; enter R_BEAT.
  - R_BEAT: rvalid=1 starting the cycle after the handshake (1-cycle latency). Beat data is registered from the array as it stood before that edge, so a same-cycle write is not visible. rlast=1 when beat==len. rvalid/rdata/rresp/rlast are held stable while rready=0.
  - On an R handshake: if beat==len, go to R_IDLE with rvalid=0 next cycle. Otherwise addr += (1<<size), beat++, and the next beat is presented the following cycle with no bubble.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1, wready=0; W beats are never accepted before AW.
  - W_DATA: wready=1. Each W handshake writes bytes of mem[(addr-MEM_BASE)>>3] where wstrb[i]=1; addr advances as for reads.
  - On wlast, enter W_RESP with bvalid=1 and bid=latched id.
  - Beats arriving after beat len without wlast are consumed but not written, and set the error flag. wlast arriving before beat len also sets the error flag.
  - W_RESP: bvalid held until bready; then W_IDLE.
- Response codes:
  - Any beat address outside [MEM_BASE, MEM_BASE+MEM_DEPTH*8): DECERR, rdata=0, write dropped.
  - Burst other than INCR (2'b01), or size>3: SLVERR for all beats, rdata=0, no writes.
  - Write error flag set: bresp=SLVERR. DECERR takes priority over SLVERR.
- Address increments wrap at 2^ADDR_W. Only beats that land inside the array are written or read.
- Read and write FSMs operate concurrently. Write commits at the clock edge and is visible to read beats registered from the next edge onward.

Optional Feature:
YSYX_AXI_RAND_DELAY_EN
- Defined: a 20-bit LFSR (seed 1, taps [19]^[18], advancing every cycle) gates arready, awready and wready, and delays first rvalid and bvalid assertion until lfsr[19]=1. Once asserted, valid is still held until the handshake.
- Undefined: fixed timing as above (readies high in idle/data states, 1-cycle read latency, bvalid the cycle after wlast).

Decomposition:
- Shared package/macros: AXI resp codes (OKAY/EXOKAY/SLVERR/DECERR), burst encodings, read/write FSM state encodings.
- One natural sub-module: ysyx_axi4_burst_addr, which computes the next beat address, in-range flag and word index from addr/size/burst. It is instantiated once for reads and once for writes.

Test Plan:
- Write single beat: awaddr=8000_0004, awsize=2, awlen=0, wdata=DEADBEEF_00000000, wstrb=F0, wlast=1 -> bvalid, bresp=00. Then read araddr=8000_0000, arsize=3 -> rdata upper word=DEADBEEF, lower word=previous contents, rlast=1, rresp=00.
- INCR read burst: araddr=8000_0010, arlen=3, arsize=3, rready toggling 1/0 -> 4 beats of words 2..5 in order; rdata stable while stalled; rlast only on beat 4; arready returns 1 the cycle after the last handshake.
- Out of range: araddr=0000_1000 -> rresp=11, rdata=0. awaddr=0000_1000 write -> bresp=11, array unchanged (verified by readback).
- Protocol error: awlen=1 with wlast on beat 0 -> bresp=10. arburst=2'b10 -> rresp=10 on every beat.
- Concurrent access: read and write of the same word accepted in the same cycle -> read returns old data; a read issued after the bvalid handshake returns the new data.
- Reset mid-burst: rst asserted during beat 2 of an arlen=7 read -> rvalid=0 next cycle, arready=1 one cycle after rst deasserts, and a fresh read completes normally.
